// File: rtl/digit_glyph_pkg.sv
// digit_glyph_pkg: shared types, sample-window geometry and the segment-pattern
// decode used by glyph_digit_reader and its per-window hit counters.
package digit_glyph_pkg;

    localparam int NUM_SEGS = 8;
    localparam int CNT_W    = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

    // Segment index, also the bit position inside seg_out.
    typedef enum logic [2:0] {
        SEG_T  = 3'd0,
        SEG_M  = 3'd1,
        SEG_B  = 3'd2,
        SEG_LU = 3'd3,
        SEG_LL = 3'd4,
        SEG_RU = 3'd5,
        SEG_RL = 3'd6,
        SEG_C  = 3'd7
    } seg_idx_e;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        ACCUM      = 2'd1,
        DECODE     = 2'd2
    } state_e;

    // Inclusive window bounds, box-relative, indexed by seg_idx_e.
    //                                            T       M       B       LU      LL      RU      RL      C
    localparam logic [11:0] WIN_X_LO [NUM_SEGS] = '{12'd41, 12'd41, 12'd41, 12'd31, 12'd31, 12'd71, 12'd71, 12'd51};
    localparam logic [11:0] WIN_X_HI [NUM_SEGS] = '{12'd60, 12'd60, 12'd60, 12'd33, 12'd33, 12'd73, 12'd73, 12'd53};
    localparam logic [11:0] WIN_Y_LO [NUM_SEGS] = '{12'd11, 12'd51, 12'd91, 12'd21, 12'd61, 12'd21, 12'd61, 12'd21};
    localparam logic [11:0] WIN_Y_HI [NUM_SEGS] = '{12'd13, 12'd53, 12'd93, 12'd40, 12'd80, 12'd40, 12'd80, 12'd40};

    // One bit per window: is the box-relative offset (dx, dy) inside it.
    function automatic logic [NUM_SEGS-1:0] window_hits(input logic [11:0] dx, input logic [11:0] dy);
        logic [NUM_SEGS-1:0] hits;
        hits = {NUM_SEGS{1'b0}};
        for (int i = 0; i < NUM_SEGS; i++) begin
            hits[i] = (dx >= WIN_X_LO[i]) && (dx <= WIN_X_HI[i]) &&
                      (dy >= WIN_Y_LO[i]) && (dy <= WIN_Y_HI[i]);
        end
        return hits;
    endfunction

    // Segment flags {C,RL,RU,LL,LU,B,M,T} -> {err, digit}; unknown patterns give {1, 4'hF}.
    function automatic logic [4:0] decode_segs(input logic [7:0] segs);
        logic [4:0] res;
        case (segs)
            8'h7D:   res = 5'h00;
            8'h80:   res = 5'h01;
            8'h37:   res = 5'h02;
            8'h67:   res = 5'h03;
            8'h6A:   res = 5'h04;
            8'h4F:   res = 5'h05;
            8'h5F:   res = 5'h06;
            8'h61:   res = 5'h07;
            8'h7F:   res = 5'h08;
            8'h6B:   res = 5'h09;
            default: res = 5'h1F;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/glyph_seg_counter.sv
// glyph_seg_counter: 6-bit saturating lit-pixel counter for one sample window.
// Exposes its next value so the decoder can include a hit still in flight.
module glyph_seg_counter
    import digit_glyph_pkg::*;
(
    input  logic             pixel_clk_in,
    input  logic             rst_in,
    input  logic             clr_in,
    input  logic             inc_in,
    output logic [CNT_W-1:0] count_next_out
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear has priority, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (clr_in) begin
            count_d = 6'd0;
        end else if (inc_in && (count_q != CNT_MAX)) begin
            count_d = count_q + 6'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q <= 6'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next_out = count_d;

endmodule

// File: rtl/glyph_digit_reader.sv
// glyph_digit_reader: reads a seven-segment digit glyph back from the pixel
// stream by counting lit pixels in eight sample windows of a WIDTH x HEIGHT box.
// Optional build macro DIGIT_DEBOUNCE_EN: publish a result only when two
// consecutive frames decode to the same value.
module glyph_digit_reader
    import digit_glyph_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 256,
    parameter int ON_THRESH = 45
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_in,
    output logic [3:0]  digit_out,
    output logic [7:0]  seg_out,
    output logic        digit_valid_out,
    output logic        digit_error_out
);

    localparam logic [11:0]      LAST_DX = 12'(WIDTH) - 12'd1;
    localparam logic [11:0]      LAST_DY = 12'(HEIGHT) - 12'd1;
    localparam logic [CNT_W-1:0] THRESH  = 6'(ON_THRESH);

    state_e state_q, state_d;
    logic [10:0] x_lat_q, x_lat_d;
    logic [9:0]  y_lat_q, y_lat_d;

    logic        pix_q, pix_d;
    logic [7:0]  hit_q, hit_d;
    logic        first_q, first_d;
    logic        last_q, last_d;

    logic [3:0]  digit_q, digit_d;
    logic [7:0]  seg_q, seg_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
`ifdef DIGIT_DEBOUNCE_EN
    logic [3:0]  prev_q, prev_d;
`endif

    logic        origin_s;
    logic [10:0] x_ref_s;
    logic [9:0]  y_ref_s;
    logic [11:0] dx_s, dy_s;
    logic        accum_s;
    logic        cnt_clr_s;
    logic [7:0]  cnt_inc_s;
    logic [CNT_W-1:0] cnt_next_s [NUM_SEGS];
    logic [7:0]  seg_s;
    logic [4:0]  dec_s;

    // Stage 1 inputs: box-relative offsets and window membership. A live origin
    // uses the incoming x_in/y_in so the origin pixel itself sees dx = dy = 0.
    always_comb begin
        origin_s = (hcount_in == x_in) && (vcount_in == y_in);
        if ((state_q == WAIT_START) || ((state_q == ACCUM) && origin_s)) begin
            x_ref_s = x_in;
            y_ref_s = y_in;
        end else begin
            x_ref_s = x_lat_q;
            y_ref_s = y_lat_q;
        end
        dx_s    = {1'b0, hcount_in} - {1'b0, x_ref_s};
        dy_s    = {2'b00, vcount_in} - {2'b00, y_ref_s};
        pix_d   = pixel_in;
        hit_d   = window_hits(dx_s, dy_s);
        first_d = (dx_s == 12'd0) && (dy_s == 12'd0);
        last_d  = (dx_s == LAST_DX) && (dy_s == LAST_DY);
    end

    // Stage 1 register.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pix_q   <= 1'b0;
            hit_q   <= 8'h00;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            hit_q   <= hit_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign cnt_inc_s = accum_s ? (hit_q & {8{pix_q}}) : 8'h00;

    for (genvar i = 0; i < NUM_SEGS; i++) begin : g_cnt
        glyph_seg_counter u_cnt (
            .pixel_clk_in   (pixel_clk_in),
            .rst_in         (rst_in),
            .clr_in         (cnt_clr_s),
            .inc_in         (cnt_inc_s[i]),
            .count_next_out (cnt_next_s[i])
        );
    end

    // Threshold every window count (including the hit still in stage 1) and decode.
    always_comb begin
        seg_s = 8'h00;
        for (int i = 0; i < NUM_SEGS; i++) begin
            seg_s[i] = (cnt_next_s[i] >= THRESH);
        end
        dec_s = decode_segs(seg_s);
    end

    // Frame FSM. The result is captured on entry to DECODE so the valid pulse is
    // presented during DECODE, two cycles after the last box pixel.
    always_comb begin
        state_d   = state_q;
        x_lat_d   = x_lat_q;
        y_lat_d   = y_lat_q;
        cnt_clr_s = 1'b0;
        accum_s   = 1'b0;
        digit_d   = digit_q;
        seg_d     = seg_q;
        err_d     = err_q;
        valid_d   = 1'b0;
`ifdef DIGIT_DEBOUNCE_EN
        prev_d    = prev_q;
`endif
        case (state_q)
            WAIT_START: begin
                if (origin_s) begin
                    x_lat_d   = x_in;
                    y_lat_d   = y_in;
                    cnt_clr_s = 1'b1;
                    state_d   = ACCUM;
                end else begin
                    state_d   = WAIT_START;
                end
            end
            ACCUM: begin
                accum_s = 1'b1;
                if (last_q) begin
                    state_d = DECODE;
`ifdef DIGIT_DEBOUNCE_EN
                    prev_d = dec_s[3:0];
                    if (dec_s[3:0] == prev_q) begin
                        digit_d = dec_s[3:0];
                        seg_d   = seg_s;
                        err_d   = dec_s[4];
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
`else
                    digit_d = dec_s[3:0];
                    seg_d   = seg_s;
                    err_d   = dec_s[4];
                    valid_d = 1'b1;
`endif
                end else if (origin_s) begin
                    // A box start without the previous box finishing: the old
                    // frame was clipped, restart on the current coordinates.
                    x_lat_d   = x_in;
                    y_lat_d   = y_in;
                    cnt_clr_s = 1'b1;
                end else if (first_q) begin
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = ACCUM;
                end
            end
            DECODE: begin
                state_d = WAIT_START;
            end
            default: begin
                state_d = WAIT_START;
            end
        endcase
    end

    // FSM, latched box origin and registered outputs.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= WAIT_START;
            x_lat_q <= 11'd0;
            y_lat_q <= 10'd0;
            digit_q <= 4'h0;
            seg_q   <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef DIGIT_DEBOUNCE_EN
            prev_q  <= 4'hE;
`endif
        end else begin
            state_q <= state_d;
            x_lat_q <= x_lat_d;
            y_lat_q <= y_lat_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef DIGIT_DEBOUNCE_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign digit_out       = digit_q;
    assign seg_out         = seg_q;
    assign digit_valid_out = valid_q;
    assign digit_error_out = err_q;

endmodule

// File: doc/glyph_digit_reader.md
Name: glyph_digit_reader

Overview:
- Reads back a seven-segment-style digit glyph from the video pixel stream; it is the decoder for the on-screen digit renderer.
- Each frame it counts lit pixels in eight fixed sample windows inside a glyph box, thresholds each window to a segment flag, and maps the flag pattern to a digit 0-9.
- Sits on the pixel clock after the compositing/camera threshold stage; the result drives overlay self-check and HUD logic.

Parameters:
- WIDTH, 256: glyph box width in pixels.
- HEIGHT, 256: glyph box height in pixels.
- ON_THRESH, 45: lit-pixel count (out of 60) at or above which a segment is declared on.

Ports:
- pixel_clk_in  input  1  pixel clock; sole clock.
- rst_in  input  1  asynchronous, active-low reset.
- x_in  input  11  glyph box left edge.
- y_in  input  10  glyph box top edge.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current pixel row.
- pixel_in  input  1  lit flag for the pixel at (hcount_in, vcount_in); aligned with the counts.
- digit_out  output  4  last decoded digit; 4'hF when the pattern is invalid.
- seg_out  output  8  last segment flags {C,RL,RU,LL,LU,B,M,T}.
- digit_valid_out  output  1  one-cycle pulse when digit_out and seg_out update.
- digit_error_out  output  1  registered with digit_out; 1 when the pattern matches no digit.

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0, counters are 0, state is WAIT_START.
- Offsets: dx = hcount - x_lat, dy = vcount - y_lat, as 12-bit unsigned values. x_lat and y_lat are latched at box start.
- Sample windows, dx/dy inclusive, each exactly 60 pixels:
  - T: dx 41..60, dy 11..13.
  - M: dx 41..60, dy 51..53.
  - B: dx 41..60, dy 91..93.
  - LU: dx 31..33, dy 21..40.
  - LL: dx 31..33, dy 61..80.
  - RU: dx 71..73, dy 21..40.
  - RL: dx 71..73, dy 61..80.
  - C: dx 51..53, dy 21..40.
- Counters: one 6-bit counter per window, saturating at 63.
- Stage 1 registers pixel_in and the 8 window-hit bits, plus first/last flags: first = (dx==0, dy==0), last = (dx==WIDTH-1, dy==HEIGHT-1).
- FSM:
  - WAIT_START: on hcount==x_in and vcount==y_in, latch x_in/y_in, clear counters, go to ACCUM.
  - ACCUM: increment hit counters when the registered pixel is 1. Registered last -> DECODE. If the origin is seen again without last (clipped or skipped box), clear counters and stay in ACCUM; no output for the dropped frame.
  - DECODE (1 cycle): seg[i] = count[i] >= ON_THRESH. Decode, register outputs, pulse valid, go to WAIT_START.
- Decode table, segments on (all others off):
  - 0: T,B,LU,LL,RU,RL.
  - 1: C.
  - 2: T,RU,M,LL,B.
  - 3: T,RU,M,RL,B.
  - 4: LU,M,RU,RL.
  - 5: T,LU,M,RL,B.
  - 6: T,LU,LL,M,RL,B.
  - 7: T,RU,RL.
  - 8: T,M,B,LU,LL,RU,RL.
  - 9: T,M,LU,RU,RL.
  - Any other pattern: digit_out=4'hF, digit_error_out=1.
- Latency: last box pixel presented in cycle N -> digit_valid_out high in cycle N+2 only.
- x_in/y_in changes mid-frame are ignored until the next WAIT_START.
- Reset asserted mid-frame discards the partial frame.
- Pixels outside the box are never counted.

Optional Feature:
- DIGIT_DEBOUNCE_EN defined: outputs update and valid pulses only when the decoded digit (including 4'hF) equals the previous frame's decode, i.e. two consecutive agreeing frames. The previous-decode register resets to 4'hE, so the first frame after reset never pulses.
- Not defined: every completed frame updates the outputs and pulses valid.

Decomposition:
- Package digit_glyph_pkg holds:
  - window bound localparams;
  - the seg index enum (T=0..C=7);
  - the FSM state enum {WAIT_START, ACCUM, DECODE};
  - function decode_segs(logic [7:0]) -> {err, digit[3:0]}.
- Sub-module glyph_seg_counter (6-bit saturating hit counter with clear/enable), instantiated 8 times.

Test Plan:
- Render digit 8 at x=100, y=50 (3-pixel strokes, 640x480 raster) -> seg_out=8'h7F, digit_out=8, error=0, one valid pulse 2 cycles after pixel (355,305).
- Sweep digits 0-9 on consecutive frames -> digit_out tracks each value, seg_out matches the table, error=0.
- Digit 1 with 20 pixels of its C window blanked (40/60 < 45) -> seg_out=0, digit_out=4'hF, error=1.
- Box at y=300 (bottom clipped at 480) -> no valid pulse; rendering next at y=50 decodes correctly.
- rst_in low for 3 cycles mid-ACCUM -> all outputs 0; the following full frame decodes with one pulse.
- DIGIT_DEBOUNCE_EN with frames 3,3,5,5 -> pulses on frames 2 and 4 only, with values 3 and 5.
